// File: rtl/key_pkg.sv
// Shared constants for the key-to-move path: default code/direction widths,
// direction indices and the default key code table.
package key_pkg;

   localparam int CODE_W_DEF  = 5;
   localparam int NUM_DIR_DEF = 4;

   localparam int DIR_UP    = 0;
   localparam int DIR_DOWN  = 1;
   localparam int DIR_LEFT  = 2;
   localparam int DIR_RIGHT = 3;

   // Slice i (LSB first) is the key code for direction i.
   localparam logic [NUM_DIR_DEF*CODE_W_DEF-1:0] KEY_CODES_DEF =
      {5'b10010, 5'b10000, 5'b10001, 5'b01101};

endpackage

// File: rtl/key_move_queue_if.sv
// Key input, move handshake and status signals of key_move_queue.
// master = the queue itself, slave = the key front end / move consumer side.
interface key_move_queue_if
   import key_pkg::*;
#(
   parameter int CODE_W  = CODE_W_DEF,
   parameter int NUM_DIR = NUM_DIR_DEF,
   parameter int DEPTH   = 4
);

   logic                     key_ready;
   logic [CODE_W-1:0]        key_code;
   logic                     move_valid;
   logic [NUM_DIR-1:0]       move_dir;
   logic                     move_ready;
   logic [NUM_DIR-1:0]       btn_pulse;
   logic [$clog2(DEPTH):0]   count;
   logic                     overflow;
   logic                     clear_overflow;

   modport master (
      input  key_ready, key_code, move_ready, clear_overflow,
      output move_valid, move_dir, btn_pulse, count, overflow
   );

   modport slave (
      output key_ready, key_code, move_ready, clear_overflow,
      input  move_valid, move_dir, btn_pulse, count, overflow
   );

endinterface

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO: dout is the head entry whenever empty=0.
// Push while full is ignored unless a pop happens in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       din,
   output logic [WIDTH-1:0]       dout,
   output logic                   empty,
   output logic                   full,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q, count_d;
   logic             wr_en, rd_en;

   assign empty = (count_q == '0);
   assign full  = (count_q == FULL_CNT);
   assign wr_en = push & (~full | pop);
   assign rd_en = pop & ~empty;
   assign dout  = mem_q[rd_ptr_q];
   assign count = count_q;

   always_comb begin
      count_d = count_q;
      case ({wr_en, rd_en})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // NOTE: storage has no reset; entries are only visible through count, which is reset.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= din;
   end

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/key_move_queue.sv
// Key strobe to buffered one-hot move queue with legacy button pulses.
// Optional auto-repeat of a held key is built when KEY_REPEAT_EN is defined.
module key_move_queue
   import key_pkg::*;
#(
   parameter int CODE_W        = CODE_W_DEF,
   parameter int NUM_DIR       = NUM_DIR_DEF,
   parameter int DEPTH         = 4,
   parameter logic [NUM_DIR*CODE_W-1:0] KEY_CODES = KEY_CODES_DEF,
   parameter int REPEAT_DELAY  = 25_000_000,
   parameter int REPEAT_PERIOD = 10_000_000
) (
   input logic              clk,
   input logic              rst_n,
   key_move_queue_if.master bus
);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1)
   begin : g_bad_cfg
      $error("key_move_queue: invalid parameter configuration");
   end

   logic               ready_q, released_q;
   logic               rise, hit, key_event, pop, drop;
   logic [NUM_DIR-1:0] dir_oh, fifo_dout, btn_pulse_q;
   logic               fifo_empty, fifo_full, overflow_q;

   // released_q blocks a key held through reset from counting as a fresh press.
   assign rise = bus.key_ready & ~ready_q & released_q;

   // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
   always_comb begin
      hit    = 1'b0;
      dir_oh = '0;
      for (int i = NUM_DIR - 1; i >= 0; i--) begin
         if (bus.key_code == KEY_CODES[i*CODE_W +: CODE_W]) begin
            hit       = 1'b1;
            dir_oh    = '0;
            dir_oh[i] = 1'b1;
         end
      end
   end

`ifdef KEY_REPEAT_EN
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RPT_W   = $clog2(RPT_MAX + 1);

   logic             armed_q, tick;
   logic [RPT_W-1:0] rpt_cnt_q;

   assign tick      = armed_q & bus.key_ready & (rpt_cnt_q == '0);
   assign key_event = (rise | tick) & hit;

   // Down-counter: reaches zero REPEAT_DELAY edges after the press, then every REPEAT_PERIOD.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         armed_q   <= 1'b0;
         rpt_cnt_q <= '0;
      end else if (!bus.key_ready) begin
         armed_q   <= 1'b0;
         rpt_cnt_q <= '0;
      end else if (rise & hit) begin
         armed_q   <= 1'b1;
         rpt_cnt_q <= RPT_W'(REPEAT_DELAY - 1);
      end else if (armed_q) begin
         rpt_cnt_q <= tick ? RPT_W'(REPEAT_PERIOD - 1) : rpt_cnt_q - RPT_W'(1);
      end
   end
`else
   assign key_event = rise & hit;
`endif

   assign pop  = ~fifo_empty & bus.move_ready;
   assign drop = key_event & fifo_full & ~pop;

   sync_fifo #(
      .WIDTH (NUM_DIR),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (key_event),
      .pop   (pop),
      .din   (dir_oh),
      .dout  (fifo_dout),
      .empty (fifo_empty),
      .full  (fifo_full),
      .count (bus.count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_q     <= 1'b0;
         released_q  <= 1'b0;
         btn_pulse_q <= '0;
         overflow_q  <= 1'b0;
      end else begin
         ready_q     <= bus.key_ready;
         released_q  <= released_q | ~bus.key_ready;
         btn_pulse_q <= key_event ? dir_oh : '0;
         // A drop in the same cycle as a clear leaves the flag set.
         if (drop)
            overflow_q <= 1'b1;
         else if (bus.clear_overflow)
            overflow_q <= 1'b0;
      end
   end

   assign bus.move_valid = ~fifo_empty;
   assign bus.move_dir   = fifo_empty ? '0 : fifo_dout;
   assign bus.btn_pulse  = btn_pulse_q;
   assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_key_move_queue.sv
// Self-checking bench for key_move_queue: directed scenarios plus random
// stimulus, all checked every cycle against a queue-based reference model.
module tb_key_move_queue;
   import key_pkg::*;

   localparam int DEPTH = 4;
   localparam int RD    = 8;
   localparam int RP    = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   key_move_queue_if #(.CODE_W(5), .NUM_DIR(4), .DEPTH(DEPTH)) bus ();

   key_move_queue #(
      .CODE_W        (5),
      .NUM_DIR       (4),
      .DEPTH         (DEPTH),
      .KEY_CODES     (KEY_CODES_DEF),
      .REPEAT_DELAY  (RD),
      .REPEAT_PERIOD (RP)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Reference model: direction table, queue of direction indices, flags.
   logic [4:0] codes [4] = '{5'b01101, 5'b10001, 5'b10000, 5'b10010};
   int   m_q[$];
   bit   m_ovf;
   bit   m_prev;
   bit   m_held;
   int   m_k;
   logic [3:0] m_pulse;

   function automatic int lookup(input logic [4:0] c);
      for (int i = 0; i < 4; i++)
         if (codes[i] == c) return i;
      return -1;
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_ovf   = 1'b0;
      m_prev  = 1'b1;   // a key held at reset must be released before it counts
      m_held  = 1'b0;
      m_k     = 0;
      m_pulse = '0;
   endtask

   task automatic compare_all();
      check("valid", 32'(bus.move_valid), 32'(m_q.size() > 0));
      check("dir", 32'(bus.move_dir), (m_q.size() > 0) ? (32'd1 << m_q[0]) : 32'd0);
      check("count", 32'(bus.count), 32'(m_q.size()));
      check("overflow", 32'(bus.overflow), 32'(m_ovf));
      check("pulse", 32'(bus.btn_pulse), 32'(m_pulse));
   endtask

   // One clock: drive inputs, advance the model at the edge, compare #1 later.
   task automatic step(input logic kr, input logic [4:0] kc, input logic mr, input logic co);
      int d;
      bit ev;
      bit drop;
      bus.key_ready      = kr;
      bus.key_code       = kc;
      bus.move_ready     = mr;
      bus.clear_overflow = co;
      @(posedge clk);
      d  = lookup(kc);
      ev = kr && !m_prev && (d >= 0);
`ifdef KEY_REPEAT_EN
      if (!kr)
         m_held = 1'b0;
      else if (!m_prev) begin
         if (d >= 0) begin
            m_held = 1'b1;
            m_k    = 0;
         end
      end else if (m_held) begin
         m_k++;
         if (m_k == RD || (m_k > RD && (m_k - RD) % RP == 0))
            ev = (d >= 0);
      end
`endif
      if (mr && m_q.size() > 0) void'(m_q.pop_front());
      drop = ev && (m_q.size() == DEPTH);
      if (ev && !drop) m_q.push_back(d);
      if (drop)
         m_ovf = 1'b1;
      else if (co)
         m_ovf = 1'b0;
      m_pulse = ev ? 4'(1 << d) : 4'b0;
      m_prev  = kr;
      #1;
      compare_all();
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_valid"}, 32'(bus.move_valid), 32'd0);
      check({tag, "_dir"}, 32'(bus.move_dir), 32'd0);
      check({tag, "_count"}, 32'(bus.count), 32'd0);
      check({tag, "_ovf"}, 32'(bus.overflow), 32'd0);
      check({tag, "_pulse"}, 32'(bus.btn_pulse), 32'd0);
   endtask

   logic [4:0] six [6] = '{5'b01101, 5'b10001, 5'b10000, 5'b10010, 5'b01101, 5'b10001};
   logic [4:0] four [4] = '{5'b10010, 5'b10000, 5'b10001, 5'b01101};

   initial begin
      logic       cur_kr;
      logic [4:0] cur_kc;
      int         n_pulses;

      bus.key_ready      = 1'b0;
      bus.key_code       = '0;
      bus.move_ready     = 1'b0;
      bus.clear_overflow = 1'b0;
      rst_n              = 1'b0;
      model_reset();
      #12;
      check_zero("rst");
      @(negedge clk);
      rst_n = 1'b1;
      step(0, 5'b0, 0, 0);
      step(0, 5'b0, 0, 0);

      // First press: pulse one cycle, move visible one cycle after the edge.
      step(1, 5'b01101, 0, 0);
      check("t1_pulse", 32'(bus.btn_pulse), 32'h1);
      check("t1_valid", 32'(bus.move_valid), 32'h1);
      check("t1_dir", 32'(bus.move_dir), 32'h1);
      check("t1_count", 32'(bus.count), 32'h1);
      step(1, 5'b01101, 0, 0);
      check("t1_pulse_end", 32'(bus.btn_pulse), 32'h0);
      step(0, 5'b0, 0, 0);
      step(0, 5'b0, 1, 0);

      // Unmapped code.
      step(1, 5'b00000, 0, 0);
      check("t2_pulse", 32'(bus.btn_pulse), 32'h0);
      check("t2_count", 32'(bus.count), 32'h0);
      check("t2_ovf", 32'(bus.overflow), 32'h0);
      step(0, 5'b0, 0, 0);

      // Six presses into a 4-deep FIFO with no consumer.
      for (int i = 0; i < 6; i++) begin
         step(1, six[i], 0, 0);
         step(0, six[i], 0, 0);
      end
      check("t3_count", 32'(bus.count), 32'h4);
      check("t3_ovf", 32'(bus.overflow), 32'h1);
      for (int i = 0; i < 4; i++) step(0, 5'b0, 1, 0);
      check("t3_ovf_held", 32'(bus.overflow), 32'h1);
      step(0, 5'b0, 0, 1);
      check("t3_ovf_clr", 32'(bus.overflow), 32'h0);

      // Full FIFO: press with pop in the same cycle, then clear racing a drop.
      for (int i = 0; i < 4; i++) begin
         step(1, four[i], 0, 0);
         step(0, four[i], 0, 0);
      end
      step(1, 5'b10010, 1, 0);
      check("t4_count", 32'(bus.count), 32'h4);
      step(0, 5'b0, 0, 0);
      step(1, 5'b10000, 0, 1);
      check("t4_set_wins", 32'(bus.overflow), 32'h1);
      step(0, 5'b0, 1, 1);
      for (int i = 0; i < 4; i++) step(0, 5'b0, 1, 0);

      // Reset in mid-stream with a key held through release.
      step(1, 5'b01101, 0, 0);
      step(0, 5'b01101, 0, 0);
      step(1, 5'b10001, 0, 0);
      rst_n = 1'b0;
      #1;
      check_zero("t5_rst");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) step(1, 5'b10001, 1, 0);
      check("t5_no_event", 32'(bus.count), 32'h0);
      step(0, 5'b10001, 1, 0);
      step(1, 5'b10001, 1, 0);
      check("t5_repress", 32'(bus.btn_pulse), 32'h2);
      step(0, 5'b0, 1, 0);

      // Randomized traffic against the model.
      cur_kr = 1'b0;
      cur_kc = 5'b0;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 9) < 3) cur_kr = ~cur_kr;
         if ($urandom_range(0, 9) < 4)
            cur_kc = ($urandom_range(0, 9) < 8) ? codes[$urandom_range(0, 3)] : 5'($urandom);
         step(cur_kr, cur_kc, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 15) == 0));
      end
      step(0, 5'b0, 1, 1);
      for (int i = 0; i < 6; i++) step(0, 5'b0, 1, 0);

`ifdef KEY_REPEAT_EN
      // Held key: events at the press edge and at +8, +12, +16, +20.
      n_pulses = 0;
      for (int k = 0; k <= 20; k++) begin
         step(1, 5'b10010, 1, 0);
         if (bus.btn_pulse != 4'b0) n_pulses++;
         check($sformatf("rpt_k%0d", k), 32'(bus.btn_pulse != 4'b0),
               32'(k == 0 || k == 8 || k == 12 || k == 16 || k == 20));
      end
      check("rpt_total", 32'(n_pulses), 32'd5);
      step(0, 5'b0, 1, 0);
`else
      n_pulses = 0;
      for (int k = 0; k <= 20; k++) begin
         step(1, 5'b10010, 1, 0);
         if (bus.btn_pulse != 4'b0) n_pulses++;
      end
      check("norpt_total", 32'(n_pulses), 32'd1);
      step(0, 5'b0, 1, 0);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
